servo_pwm_control: RTL and testbench

Servo PWM generator for the solar tracker. Produces a fixed-period PWM on `SERVO` whose high time `pulseWidth` (in CLK cycles) is stepped up or down by a direction command or by an automatic sweep request. The block is instantiated by the servo driver, which derives `DIR` from buttons and monitors `pulseWidth` as the servo position.

---
 rtl/servo_pwm_control.sv | 128 ++++++++++++
 tb/tb_servo_pwm_control.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_control.sv
// Servo PWM generator: fixed-period PWM whose high time is stepped by DIR or by a sweep tick.
// Optional sweep logic (ES/MC) is compiled in when PWM_SWEEP_EN is defined.
module servo_pwm_control #(
  parameter int unsigned PERIOD  = 2_000_000,
  parameter int unsigned PW_MIN  = 50_000,
  parameter int unsigned PW_INIT = 150_000,
  parameter int unsigned STEP    = 100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  DIR,
  input  logic        EN,
  input  logic        MC,
  input  logic        ES,
  input  logic [31:0] pulseWidth_max,
  output logic [31:0] pulseWidth,
  output logic        SERVO
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned PW_W  = 32;
  localparam int unsigned EXT_W = PW_W + 1;

  logic [CNT_W-1:0] r_cnt;
  logic [PW_W-1:0]  r_pw;
  logic             r_servo;

  logic             w_boundary;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_servo_next;
  logic [EXT_W-1:0] w_hi;
  logic [EXT_W-1:0] w_pw_ext;
  logic [EXT_W-1:0] w_inc_sum;
  logic [EXT_W-1:0] w_inc;
  logic [EXT_W-1:0] w_dec;
  logic [EXT_W-1:0] w_pw_next;
  logic             w_sweep_step;

`ifdef PWM_SWEEP_EN
  logic r_sweep_pending;
  logic w_sweep_pending_next;

  // MC on the boundary cycle itself is carried into the following period.
  always_comb begin
    w_sweep_pending_next = r_sweep_pending;
    w_sweep_step         = 1'b0;
    if (!ES) begin
      w_sweep_pending_next = 1'b0;
    end else if (w_boundary) begin
      w_sweep_step         = r_sweep_pending;
      w_sweep_pending_next = MC;
    end else if (MC) begin
      w_sweep_pending_next = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sweep_pending <= 1'b0;
    end else begin
      r_sweep_pending <= w_sweep_pending_next;
    end
  end
`else
  logic w_unused_sweep;
  assign w_unused_sweep = ES ^ MC;
  assign w_sweep_step   = 1'b0;
`endif

  assign w_boundary = EN && (r_cnt == CNT_W'(PERIOD - 1));

  // Period counter and registered PWM compare.
  always_comb begin
    w_cnt_next   = r_cnt;
    w_servo_next = 1'b0;
    if (EN) begin
      w_cnt_next   = w_boundary ? '0 : r_cnt + CNT_W'(1);
      w_servo_next = (PW_W'(r_cnt) < r_pw);
    end
  end

  // Next pulse width, all arithmetic one bit wider than the register.
  always_comb begin
    w_pw_ext  = EXT_W'(r_pw);
    w_hi      = (EXT_W'(pulseWidth_max) > EXT_W'(PW_MIN)) ? EXT_W'(pulseWidth_max)
                                                          : EXT_W'(PW_MIN);
    w_inc_sum = w_pw_ext + EXT_W'(STEP);
    w_inc     = (w_inc_sum > w_hi) ? w_hi : w_inc_sum;
    w_dec     = (w_pw_ext < (EXT_W'(PW_MIN) + EXT_W'(STEP))) ? EXT_W'(PW_MIN)
                                                             : w_pw_ext - EXT_W'(STEP);
    w_pw_next = w_pw_ext;
    if (w_boundary) begin
      if (pulseWidth_max < r_pw) begin
        w_pw_next = w_hi;
      end else if (w_sweep_step) begin
        w_pw_next = w_inc;
      end else begin
`ifdef PWM_SWEEP_EN
        if (!ES) begin
`else
        begin
`endif
          case (DIR)
            2'b01:   w_pw_next = w_inc;
            2'b10:   w_pw_next = w_dec;
            default: w_pw_next = w_pw_ext;
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt   <= '0;
      r_pw    <= PW_W'(PW_INIT);
      r_servo <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_pw    <= PW_W'(w_pw_next);
      r_servo <= w_servo_next;
    end
  end

  assign pulseWidth = r_pw;
  assign SERVO      = r_servo;

endmodule

// File: tb/tb_servo_pwm_control.sv
// Directed bench for servo_pwm_control with PERIOD=100, PW_MIN=10, PW_INIT=50, STEP=5.
// Sweep expectations follow PWM_SWEEP_EN.
module tb_servo_pwm_control;

  logic        CLK;
  logic        RST;
  logic [1:0]  DIR;
  logic        EN;
  logic        MC;
  logic        ES;
  logic [31:0] pulseWidth_max;
  logic [31:0] pulseWidth;
  logic        SERVO;

  int checks;
  int errors;

  servo_pwm_control #(
    .PERIOD (100),
    .PW_MIN (10),
    .PW_INIT(50),
    .STEP   (5)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .DIR           (DIR),
    .EN            (EN),
    .MC            (MC),
    .ES            (ES),
    .pulseWidth_max(pulseWidth_max),
    .pulseWidth    (pulseWidth),
    .SERVO         (SERVO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_cycles(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (SERVO === 1'b1) hi++;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    check("rst_servo", 64'(SERVO), 64'd0);
    tick();
    check("rst_pw", 64'(pulseWidth), 64'd50);
    RST = 1'b0;
  endtask

  // One period with MC pulses on cycles 10,20,..; optionally drop ES on cycle es_off_at.
  task automatic run_mc_period(input int npulse, input int es_off_at, output int hi);
    hi = 0;
    for (int i = 1; i <= 100; i++) begin
      MC = ((i % 10) == 0) && ((i / 10) <= npulse);
      if (es_off_at != 0 && i == es_off_at) ES = 1'b0;
      tick();
      if (SERVO === 1'b1) hi++;
    end
    MC = 1'b0;
  endtask

  initial begin
    int hi;
    int exp_pw;
    checks = 0;
    errors = 0;
    RST = 1'b1;
    DIR = 2'b00;
    EN = 1'b1;
    MC = 1'b0;
    ES = 1'b0;
    pulseWidth_max = 32'd80;
    tick();

    // Hold for three periods
    do_reset();
    for (int p = 0; p < 3; p++) begin
      run_cycles(100, hi);
      check("hold_high", 64'(hi), 64'd50);
    end
    check("hold_pw", 64'(pulseWidth), 64'd50);

    // Increase with saturation at pulseWidth_max
    DIR = 2'b01;
    for (int p = 1; p <= 10; p++) begin
      run_cycles(100, hi);
      exp_pw = (50 + 5 * p > 80) ? 80 : 50 + 5 * p;
      check("inc_pw", 64'(pulseWidth), 64'(exp_pw));
    end
    DIR = 2'b00;
    run_cycles(100, hi);
    check("inc_high80", 64'(hi), 64'd80);

    // Decrease with floor at PW_MIN
    do_reset();
    DIR = 2'b10;
    for (int p = 1; p <= 10; p++) begin
      run_cycles(100, hi);
      exp_pw = (50 - 5 * p < 10) ? 10 : 50 - 5 * p;
      check("dec_pw", 64'(pulseWidth), 64'(exp_pw));
    end
    DIR = 2'b00;
    run_cycles(100, hi);
    check("dec_high10", 64'(hi), 64'd10);

    // Sweep: several MC pulses yield one step per period
    do_reset();
    ES = 1'b1;
    run_mc_period(3, 0, hi);
`ifdef PWM_SWEEP_EN
    exp_pw = 55;
`else
    exp_pw = 50;
`endif
    check("sweep_pw1", 64'(pulseWidth), 64'(exp_pw));
    run_mc_period(1, 0, hi);
    check("sweep_high2", 64'(hi), 64'(exp_pw));
`ifdef PWM_SWEEP_EN
    exp_pw = 60;
`endif
    check("sweep_pw2", 64'(pulseWidth), 64'(exp_pw));
    run_mc_period(1, 50, hi);
    check("sweep_exit_pw", 64'(pulseWidth), 64'(exp_pw));
    ES = 1'b0;

    // pulseWidth_max dropping below pulseWidth
    do_reset();
    DIR = 2'b01;
    for (int p = 0; p < 6; p++) run_cycles(100, hi);
    check("max_pre_pw", 64'(pulseWidth), 64'd80);
    DIR = 2'b00;
    pulseWidth_max = 32'd40;
    run_cycles(100, hi);
    check("max40_pw", 64'(pulseWidth), 64'd40);
    pulseWidth_max = 32'd5;
    run_cycles(100, hi);
    check("max40_high", 64'(hi), 64'd40);
    check("max5_pw", 64'(pulseWidth), 64'd10);
    run_cycles(100, hi);
    check("max5_high", 64'(hi), 64'd10);
    pulseWidth_max = 32'd80;

    // EN low mid-period freezes the counter
    do_reset();
    run_cycles(30, hi);
    check("en_pre_high", 64'(hi), 64'd30);
    EN = 1'b0;
    run_cycles(20, hi);
    check("en_off_high", 64'(hi), 64'd0);
    EN = 1'b1;
    run_cycles(70, hi);
    check("en_resume_high", 64'(hi), 64'd20);
    run_cycles(100, hi);
    check("en_full_high", 64'(hi), 64'd50);

    // Reset mid-period restores PW_INIT and restarts the count
    DIR = 2'b01;
    run_cycles(100, hi);
    check("rst_mid_pre_pw", 64'(pulseWidth), 64'd55);
    DIR = 2'b00;
    run_cycles(37, hi);
    check("rst_mid_pre_high", 64'(hi), 64'd37);
    do_reset();
    tick();
    check("rst_first_high", 64'(SERVO), 64'd1);
    run_cycles(99, hi);
    check("rst_rest_high", 64'(hi), 64'd49);
    check("rst_end_pw", 64'(pulseWidth), 64'd50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
